iteration_sequencer: RTL and testbench
======================================

# iteration_sequencer

Parametrised iteration controller for the sequential arithmetic datapaths. Arms on a level `start` button, triggers on its release, and runs a programmable number of single-cycle iteration steps. It drives the datapath with step, first/last and index information, then issues a done pulse. It generalises the fixed-count shot controller with:
- runtime length
- abort
- busy/done handshake
- an optional input debouncer

## Interface
Parameters:
- `MAX_ITER`, default 32: largest supported iteration count.
- `LEN_W`, default CeilLog2(MAX_ITER+1): width of `len`.
- `IDX_W`, default CeilLog2(MAX_ITER): width of `iter_idx`.
- `DEBOUNCE_CYCLES`, default 4: consecutive stable samples required by the debouncer.

Ports:
- `clk` input 1: sole clock, all logic on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: level request from a button or host, triggered on release.
- `len` input LEN_W: iteration count, latched on trigger; values above MAX_ITER are clamped to MAX_ITER.
- `abort` input 1: cancels an armed or running sequence.
- `busy` output 1: high in ARMED and RUN.
- `step` output 1: one iteration enable per cycle while in RUN.
- `iter_idx` output IDX_W: current iteration index, 0..len-1.
- `first` output 1: step && iter_idx==0.
- `last` output 1: step && iter_idx==len_q-1.
- `done` output 1: one-cycle pulse at sequence completion.
- `aborted` output 1: one-cycle pulse when an abort is taken.

## Operation
States: IDLE, ARMED, RUN, DONE, ABORT.
- **IDLE:**
  - start_f=1 goes to ARMED.
  - abort is ignored.
- **ARMED:**
  - abort=1 goes to ABORT, with priority over start.
  - start_f=0 (release) latches len_q=min(len,MAX_ITER) and clears iter_idx.
  - After the release, len_q==0 goes to DONE and len_q>0 goes to RUN.
- **RUN:**
  - step=1 every cycle.
  - iter_idx increments after each step.
  - On the step with iter_idx==len_q-1, go to DONE.
  - abort=1 goes to ABORT; the step in that cycle is still asserted, and no further steps follow.
  - start is ignored throughout RUN.
- **DONE:** done=1 for one cycle, iter_idx is cleared, then go to IDLE.
- **ABORT:** aborted=1 for one cycle, iter_idx is cleared, then go to IDLE.
- **start held after completion:** if start is still high when IDLE is re-entered, the block goes to ARMED. The next sequence needs a fresh release.
- **Counter arithmetic:** iter_idx never exceeds len_q-1 and never wraps inside a sequence.
- **Latching of len:** len is sampled only at the trigger edge. Changes to len during RUN have no effect.

## Timing
- **Reset values:** state=IDLE, len_q=0, iter_idx=0, and busy, step, first, last, done, aborted all 0.
- Reset during any state returns the block to IDLE on the next edge; an in-flight sequence produces no done or aborted pulse.
- All outputs are decoded from registered state and counter, with no combinational path from inputs to outputs.
- **Trigger latency:**
  - Release sampled at edge k leaves ARMED.
  - step and first are high in cycle k+1.
  - Steps occupy cycles k+1..k+len_q, and done is high in cycle k+len_q+1.
  - For len_q==0, done is high in cycle k+1 with no steps.
  - Release to done is len_q+1 cycles, excluding debounce delay.
- For len_q==1, first and last are high in the same cycle.
- **Abort latency:** abort sampled at edge m gives aborted in cycle m+1; busy is low from cycle m+1.

## Configuration
Macro `ITER_SEQ_DEBOUNCE_EN`.
- **Defined:**
  - `start` passes through a 2-flop synchronizer, then a stability counter.
  - start_f changes only after DEBOUNCE_CYCLES consecutive equal synchronized samples.
  - Reset value of start_f is 0.
  - Added latency is 2+DEBOUNCE_CYCLES cycles on each edge of start.
  - Glitches shorter than DEBOUNCE_CYCLES are rejected.
- **Undefined:** start_f = start, used directly with zero added latency. The input must already be synchronous to `clk`.

## Structure
- **Package `iter_seq_pkg`:**
  - enum typedef `iter_state_t` {IDLE, ARMED, RUN, DONE, ABORT}.
  - Function `CeilLog2`.
- **Sub-module `start_debounce`:**
  - Parameter DEBOUNCE_CYCLES; ports clk, reset, din, dout.
  - Instantiated only under `ITER_SEQ_DEBOUNCE_EN`.

## Test plan
Debounce off unless stated.
- **Basic run:** reset, then len=32, start high for 3 cycles, then low → busy in ARMED; 32 steps with iter_idx 0..31; first in step 1, last in step 32; done one cycle after the last step; back to IDLE.
- **Boundary lengths:**
  - len=0 → done in the cycle after release, no step.
  - len=1 → one step with first and last high together.
  - len=40 with MAX_ITER=32 → 32 steps.
- **Abort:**
  - abort at step with iter_idx=5 → that step is seen, aborted pulses next cycle, done never asserts, iter_idx=0.
  - abort in ARMED with start released in the same cycle → ABORT wins, no steps.
- **Mid-run disturbance:**
  - start toggled and len changed during RUN → step count and done timing are unchanged.
  - start held through DONE → ARMED re-entered, no steps until a fresh release.
- **Reset mid-run:** reset asserted at step 10 for 1 cycle → all outputs 0 next cycle, no done; a subsequent normal run works.
- **Debounce on** (DEBOUNCE_CYCLES=4):
  - 2-cycle start glitch → no arming.
  - Clean press and release → first step 2+4+1 cycles after the sampled release.

Source files
------------

// File: rtl/iteration_sequencer_pkg.sv
// Shared types and helpers for the iteration sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package iter_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ARMED,
    RUN,
    DONE,
    ABORT
  } iter_state_t;

  // Ceiling of log2(n), floored at 1 so derived widths are never zero.
  function automatic int CeilLog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/iteration_sequencer_debounce.sv
// Start-button conditioner: 2-flop synchronizer followed by a stability counter.
// Latency: 2 + DEBOUNCE_CYCLES cycles on each edge of din.
// Backpressure: none; pulses shorter than DEBOUNCE_CYCLES never reach dout.
module start_debounce
  import iter_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int CNT_W = CeilLog2(DEBOUNCE_CYCLES + 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Synchronize din, then only accept a new level after it has been stable long enough.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      dout  <= 1'b0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 == dout) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        dout <= sync2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/iteration_sequencer.sv
// Iteration controller: arms on start, triggers on release, issues len single-cycle steps, then done.
// Latency: first step one cycle after the sampled release; done len_q+1 cycles after release.
// Backpressure: none; abort cancels ARMED/RUN. Optional debouncer: define ITER_SEQ_DEBOUNCE_EN.
module iteration_sequencer
  import iter_seq_pkg::*;
#(
  parameter int MAX_ITER        = 32,
  parameter int LEN_W           = CeilLog2(MAX_ITER + 1),
  parameter int IDX_W           = CeilLog2(MAX_ITER),
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             abort,
  output logic             busy,
  output logic             step,
  output logic [IDX_W-1:0] iter_idx,
  output logic             first,
  output logic             last,
  output logic             done,
  output logic             aborted
);

  iter_state_t      state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_clamped;
  logic             start_f;

`ifdef ITER_SEQ_DEBOUNCE_EN
  start_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_start_debounce (
    .clk  (clk),
    .reset(reset),
    .din  (start),
    .dout (start_f)
  );
`else
  // start is assumed already synchronous to clk in this build.
  assign start_f = start;
`endif

  assign len_clamped = (len > LEN_W'(MAX_ITER)) ? LEN_W'(MAX_ITER) : len;

  // Sequencer FSM; every output is registered alongside the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      len_q    <= '0;
      iter_idx <= '0;
      busy     <= 1'b0;
      step     <= 1'b0;
      first    <= 1'b0;
      last     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      step    <= 1'b0;
      first   <= 1'b0;
      last    <= 1'b0;
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (start_f) begin
            state <= ARMED;
            busy  <= 1'b1;
          end
        end
        ARMED: begin
          if (abort) begin
            state    <= ABORT;
            busy     <= 1'b0;
            aborted  <= 1'b1;
            iter_idx <= '0;
          end else if (!start_f) begin
            len_q    <= len_clamped;
            iter_idx <= '0;
            if (len_clamped == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              step  <= 1'b1;
              first <= 1'b1;
              last  <= (len_clamped == LEN_W'(1));
            end
          end
        end
        RUN: begin
          // The step visible this cycle has already been issued; abort only stops later ones.
          if (abort) begin
            state    <= ABORT;
            busy     <= 1'b0;
            aborted  <= 1'b1;
            iter_idx <= '0;
          end else if (LEN_W'(iter_idx) == len_q - LEN_W'(1)) begin
            state    <= DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            iter_idx <= '0;
          end else begin
            iter_idx <= iter_idx + IDX_W'(1);
            step     <= 1'b1;
            last     <= (LEN_W'(iter_idx) + LEN_W'(2) == len_q);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        ABORT: begin
          state <= IDLE;
        end
        default: begin
          state    <= IDLE;
          busy     <= 1'b0;
          iter_idx <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iteration_sequencer.sv
// Directed self-checking bench for iteration_sequencer (MAX_ITER=32).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Debounce-specific steps run only when ITER_SEQ_DEBOUNCE_EN is defined.
module tb_iteration_sequencer;

  localparam int MAX_ITER = 32;
  localparam int LEN_W    = 6;
  localparam int IDX_W    = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [LEN_W-1:0] len;
  logic             abort;
  logic             busy;
  logic             step;
  logic [IDX_W-1:0] iter_idx;
  logic             first;
  logic             last;
  logic             done;
  logic             aborted;

  iteration_sequencer #(
    .MAX_ITER       (MAX_ITER),
    .LEN_W          (LEN_W),
    .IDX_W          (IDX_W),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .len     (len),
    .abort   (abort),
    .busy    (busy),
    .step    (step),
    .iter_idx(iter_idx),
    .first   (first),
    .last    (last),
    .done    (done),
    .aborted (aborted)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  int c_steps, c_cycles, c_idx_bad, c_first_n, c_first_at, c_last_n, c_last_at;
  int c_fl_same, c_done, c_abort;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] outs();
    return {busy, step, first, last, done, aborted};
  endfunction

  // Watch from the current cycle until done/aborted or the budget runs out.
  task automatic collect(input int budget, input bit disturb);
    c_steps = 0; c_cycles = 0; c_idx_bad = 0; c_first_n = 0; c_first_at = -1;
    c_last_n = 0; c_last_at = -1; c_fl_same = 0;
    while (done !== 1'b1 && aborted !== 1'b1 && c_cycles < budget) begin
      if (step === 1'b1) begin
        if (iter_idx !== IDX_W'(c_steps)) c_idx_bad++;
        if (first === 1'b1) begin c_first_n++; c_first_at = c_steps; end
        if (last === 1'b1) begin
          c_last_n++; c_last_at = c_steps;
          if (first === 1'b1) c_fl_same = 1;
        end
        c_steps++;
      end
      if (disturb) begin
        start = ~start;
        len   = LEN_W'(3);
      end
      tick();
      c_cycles++;
    end
    c_done  = (done === 1'b1) ? 1 : 0;
    c_abort = (aborted === 1'b1) ? 1 : 0;
    if (disturb) start = 1'b0;
  endtask

  // One-cycle press, then release sampled on the following edge.
  task automatic press_release(input int l);
    start = 1'b1;
    tick();
    start = 1'b0;
    len   = LEN_W'(l);
    tick();
  endtask

  initial begin
    int n;
    reset = 1'b1; start = 1'b0; abort = 1'b0; len = '0;
    tick(); tick();
    chk("reset_outs", 32'(outs()), 32'd0);
    chk("reset_idx", 32'(iter_idx), 32'd0);
    reset = 1'b0;
    tick();

`ifdef ITER_SEQ_DEBOUNCE_EN
    // Short glitches must never arm the sequencer.
    start = 1'b1; tick(); tick(); start = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("deb_glitch2_busy", 32'(busy), 32'd0);
    start = 1'b1; tick(); tick(); tick(); start = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("deb_glitch3_busy", 32'(busy), 32'd0);
    // Clean press arms after 2+4 cycles of conditioning.
    len = LEN_W'(4);
    start = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("deb_press_busy", 32'(busy), 32'd1);
    start = 1'b0;
    tick();
    n = 1;
    while (step !== 1'b1 && n < 30) begin tick(); n++; end
    chk("deb_release_to_step", 32'(n), 32'd7);
    chk("deb_first", 32'(first), 32'd1);
    collect(40, 1'b0);
    chk("deb_steps", 32'(c_steps), 32'd4);
    chk("deb_done", 32'(c_done), 32'd1);
    chk("deb_idx_seq", 32'(c_idx_bad), 32'd0);
    tick(); tick();
    chk("deb_idle", 32'(outs()), 32'd0);
`else
    // Basic run, len=32 with a 3-cycle press.
    len = LEN_W'(32);
    start = 1'b1; tick(); tick(); tick();
    chk("basic_armed_busy", 32'(outs()), 32'b100000);
    start = 1'b0;
    tick();
    chk("basic_first_cycle", 32'(outs()), 32'b111000);
    chk("basic_first_idx", 32'(iter_idx), 32'd0);
    collect(100, 1'b0);
    chk("basic_steps", 32'(c_steps), 32'd32);
    chk("basic_done_cycle", 32'(c_cycles), 32'd32);
    chk("basic_idx_seq", 32'(c_idx_bad), 32'd0);
    chk("basic_first_at", 32'(c_first_at), 32'd0);
    chk("basic_first_n", 32'(c_first_n), 32'd1);
    chk("basic_last_at", 32'(c_last_at), 32'd31);
    chk("basic_last_n", 32'(c_last_n), 32'd1);
    chk("basic_done_outs", 32'(outs()), 32'b000010);
    chk("basic_done_idx", 32'(iter_idx), 32'd0);
    tick();
    chk("basic_idle", 32'(outs()), 32'd0);

    // len=0: done right after release, no step.
    press_release(0);
    chk("len0_outs", 32'(outs()), 32'b000010);
    collect(10, 1'b0);
    chk("len0_steps", 32'(c_steps), 32'd0);
    tick();

    // len=1: first and last together.
    press_release(1);
    collect(10, 1'b0);
    chk("len1_steps", 32'(c_steps), 32'd1);
    chk("len1_first_last", 32'(c_fl_same), 32'd1);
    chk("len1_done_cycle", 32'(c_cycles), 32'd1);
    tick();

    // len=40 clamps to 32.
    press_release(40);
    collect(100, 1'b0);
    chk("len40_steps", 32'(c_steps), 32'd32);
    chk("len40_last_at", 32'(c_last_at), 32'd31);
    chk("len40_done", 32'(c_done), 32'd1);
    tick();

    // Abort on the step with iter_idx=5.
    press_release(20);
    n = 0;
    while (!(step === 1'b1 && iter_idx === IDX_W'(5)) && n < 40) begin tick(); n++; end
    chk("abort_reach_idx5", 32'(iter_idx), 32'd5);
    chk("abort_step_seen", 32'(step), 32'd1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_pulse", 32'(outs()), 32'b000001);
    chk("abort_idx", 32'(iter_idx), 32'd0);
    tick();
    collect(30, 1'b0);
    chk("abort_no_done", 32'(c_done), 32'd0);
    chk("abort_no_steps", 32'(c_steps), 32'd0);

    // Abort in ARMED coinciding with release: abort wins.
    len = LEN_W'(5);
    start = 1'b1; tick();
    start = 1'b0; abort = 1'b1; tick();
    abort = 1'b0;
    chk("armed_abort_pulse", 32'(outs()), 32'b000001);
    tick();
    collect(15, 1'b0);
    chk("armed_abort_steps", 32'(c_steps), 32'd0);
    chk("armed_abort_no_done", 32'(c_done), 32'd0);

    // start toggled and len changed during RUN.
    press_release(8);
    collect(40, 1'b1);
    chk("disturb_steps", 32'(c_steps), 32'd8);
    chk("disturb_done_cycle", 32'(c_cycles), 32'd8);
    chk("disturb_last_at", 32'(c_last_at), 32'd7);
    tick(); tick();
    chk("disturb_idle", 32'(outs()), 32'd0);

    // start held through DONE re-arms, no steps until a fresh release.
    press_release(2);
    start = 1'b1;
    collect(10, 1'b0);
    chk("held_run_steps", 32'(c_steps), 32'd2);
    tick(); tick();
    chk("held_rearmed", 32'(outs()), 32'b100000);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (step === 1'b1) n++;
      tick();
    end
    chk("held_no_steps", 32'(n), 32'd0);
    start = 1'b0; len = LEN_W'(2);
    tick();
    chk("held_fresh_first", 32'(outs()), 32'b111000);
    collect(10, 1'b0);
    chk("held_fresh_steps", 32'(c_steps), 32'd2);
    tick();

    // Reset at step 10, then a normal run.
    press_release(20);
    n = 0;
    while (!(step === 1'b1 && iter_idx === IDX_W'(10)) && n < 40) begin tick(); n++; end
    chk("rst_reach_idx10", 32'(iter_idx), 32'd10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_outs", 32'(outs()), 32'd0);
    chk("rst_idx", 32'(iter_idx), 32'd0);
    collect(25, 1'b0);
    chk("rst_no_done", 32'(c_done), 32'd0);
    chk("rst_no_steps", 32'(c_steps), 32'd0);
    press_release(3);
    collect(10, 1'b0);
    chk("rst_after_steps", 32'(c_steps), 32'd3);
    chk("rst_after_done", 32'(c_done), 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
